seh_or_tree_pipe: RTL and testbench



---
 rtl/seh_or_pkg.sv | 64 ++++++
 rtl/seh_or_node.sv | 52 +++++
 rtl/seh_or_tree_pipe.sv | 149 ++++++++++++++
 tb/tb_seh_or_tree_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seh_or_pkg.sv
// seh_or_pkg
//   Shared helpers for the pipelined OR-reduction tree.
//   - clog2 / idx_width  : index width derivation (minimum 1 bit)
//   - ceil_div           : integer ceiling divide
//   - num_stages         : number of registered OR levels, minimum 1
//   - stage_nodes        : node count of a given stage
//   - stage_offset       : position of a stage inside the flattened node buses
//   - or_bundle_t        : {valid, x, idx} result bundle (idx sized for WIDTH=256)
package seh_or_pkg;

   localparam int MAX_IDXW = 8;

   typedef struct packed {
      logic                valid;
      logic                x;
      logic [MAX_IDXW-1:0] idx;
   } or_bundle_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int idx_width(input int width);
      return (clog2(width) < 1) ? 1 : clog2(width);
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Levels needed to collapse width inputs into one node; at least one
   // level always exists so a narrow input still gets a registered node.
   function automatic int num_stages(input int width, input int fanin);
      int n;
      int l;
      n = width;
      l = 0;
      do begin
         n = ceil_div(n, fanin);
         l++;
      end while (n > 1);
      return l;
   endfunction

   // Number of nodes produced by stage s (stage 0 reads the raw inputs).
   function automatic int stage_nodes(input int width, input int fanin, input int s);
      int n;
      n = width;
      for (int i = 0; i <= s; i++) n = ceil_div(n, fanin);
      return n;
   endfunction

   // First node position of stage s in the flattened per-node buses.
   function automatic int stage_offset(input int width, input int fanin, input int s);
      int off;
      off = 0;
      for (int i = 0; i < s; i++) off += stage_nodes(width, fanin, i);
      return off;
   endfunction

endpackage

// File: rtl/seh_or_node.sv
// seh_or_node
//   One registered FANIN-input OR node with a lowest-set-input index encoder.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     x_i          : child OR results (unused children tied to 0 by the parent)
//     idx_i        : child indices, FANIN packed fields of IDXW bits
//     x_o, idx_o   : registered OR and index of the lowest set child
//     x_d_o,idx_d_o: the same values one cycle early (next-state taps), used
//                    by the top to fold the final result into the sticky
//                    accumulator on the same edge the last stage registers
module seh_or_node #(
   parameter int FANIN = 4,
   parameter int IDXW  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [FANIN-1:0]      x_i,
   input  logic [FANIN*IDXW-1:0] idx_i,
   output logic                  x_o,
   output logic [IDXW-1:0]       idx_o,
   output logic                  x_d_o,
   output logic [IDXW-1:0]       idx_d_o
);

   logic            x_d, x_q;
   logic [IDXW-1:0] idx_d, idx_q;

   // Scan from the top child down so the lowest set child is assigned last.
   always_comb begin
      x_d   = |x_i;
      idx_d = '0;
      for (int j = FANIN - 1; j >= 0; j--) begin
         if (x_i[j]) idx_d = idx_i[j*IDXW +: IDXW];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q   <= 1'b0;
         idx_q <= '0;
      end else begin
         x_q   <= x_d;
         idx_q <= idx_d;
      end
   end

   assign x_o     = x_q;
   assign idx_o   = idx_q;
   assign x_d_o   = x_d;
   assign idx_d_o = idx_d;

endmodule

// File: rtl/seh_or_tree_pipe.sv
// seh_or_tree_pipe
//   Pipelined, masked WIDTH-input OR reduction with lowest-set-bit index and
//   optional sticky accumulation. Latency in_valid -> out_valid is L cycles,
//   L = number of FANIN-wide OR levels. No backpressure.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     in_valid          : sample qualifier
//     in_data, in_mask  : bits to reduce; mask 0 forces a bit to 0
//     clr               : sticky clear (ignored when STICKY=0)
//     out_valid         : one pulse per sample, L cycles after in_valid
//     out_x, out_idx    : OR result / lowest set index (accumulated if STICKY)
//     out_any_since_clr : accumulator level in sticky mode, else 0
//   Handshake: in_valid=1 on a rising edge accepts a sample unconditionally;
//   out_valid=1 marks the cycle that sample's result is presented.
module seh_or_tree_pipe
   import seh_or_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int FANIN  = 4,
   parameter int STICKY = 0,
   // Derived from WIDTH; leave at its default.
   parameter int IDXW   = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_mask,
   input  logic             clr,
   output logic             out_valid,
   output logic             out_x,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_any_since_clr
);

   localparam int L   = num_stages(WIDTH, FANIN);
   localparam int TOT = stage_offset(WIDTH, FANIN, L);

   // Flattened per-node results for every stage; the last entry is the root.
   logic [TOT-1:0]      x_all;
   logic [TOT*IDXW-1:0] idx_all;
   logic [TOT-1:0]      tap_x;
   logic [TOT*IDXW-1:0] tap_idx;

   // Valid shift register; vld_chain[i] is the valid entering stage i.
   logic [L-1:0] vld_q;
   logic [L:0]   vld_chain;

   assign vld_chain = {vld_q, in_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_chain[L-1:0];
   end

   for (genvar s = 0; s < L; s++) begin : g_stg
      localparam int NIN  = (s == 0) ? WIDTH : stage_nodes(WIDTH, FANIN, s - 1);
      localparam int NOUT = stage_nodes(WIDTH, FANIN, s);
      localparam int OFF  = stage_offset(WIDTH, FANIN, s);

      logic [NIN-1:0]      cx;
      logic [NIN*IDXW-1:0] cidx;

      if (s == 0) begin : g_src
         assign cx = in_data & in_mask;
         // Leaf indices are the bit positions themselves.
         for (genvar b = 0; b < NIN; b++) begin : g_leaf
            assign cidx[b*IDXW +: IDXW] = IDXW'(b);
         end
      end else begin : g_prev
         localparam int POFF = stage_offset(WIDTH, FANIN, s - 1);
         assign cx   = x_all[POFF +: NIN];
         assign cidx = idx_all[POFF*IDXW +: NIN*IDXW];
      end

      for (genvar n = 0; n < NOUT; n++) begin : g_node
         logic [FANIN-1:0]      nx;
         logic [FANIN*IDXW-1:0] nidx;

         // Children past the end of a partial last group read as 0.
         for (genvar j = 0; j < FANIN; j++) begin : g_in
            if (n * FANIN + j < NIN) begin : g_real
               assign nx[j]                 = cx[n*FANIN + j];
               assign nidx[j*IDXW +: IDXW]  = cidx[(n*FANIN + j)*IDXW +: IDXW];
            end else begin : g_pad
               assign nx[j]                 = 1'b0;
               assign nidx[j*IDXW +: IDXW]  = '0;
            end
         end

         seh_or_node #(
            .FANIN (FANIN),
            .IDXW  (IDXW)
         ) u_node (
            .clk_i   (clk),
            .rst_i   (rst),
            .x_i     (nx),
            .idx_i   (nidx),
            .x_o     (x_all[OFF + n]),
            .idx_o   (idx_all[(OFF + n)*IDXW +: IDXW]),
            .x_d_o   (tap_x[OFF + n]),
            .idx_d_o (tap_idx[(OFF + n)*IDXW +: IDXW])
         );
      end
   end

   assign out_valid = vld_q[L-1];

   if (STICKY != 0) begin : g_sticky
      logic            acc_q, acc_d;
      logic [IDXW-1:0] idx_hold_q, idx_hold_d;
      logic            hit;

      // The accumulator is fed from the root node's next-state taps so the
      // folded result becomes visible on the same edge as out_valid.
      always_comb begin
         hit        = vld_chain[L-1] & tap_x[TOT-1];
         acc_d      = (clr ? 1'b0 : acc_q) | hit;
         idx_hold_d = idx_hold_q;
         // Index is captured only when the accumulator is (re)armed; a clear
         // in the same cycle as a hit lets the new index win.
         if (hit && (clr || !acc_q)) idx_hold_d = tap_idx[(TOT-1)*IDXW +: IDXW];
         else if (clr)               idx_hold_d = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_q      <= 1'b0;
            idx_hold_q <= '0;
         end else begin
            acc_q      <= acc_d;
            idx_hold_q <= idx_hold_d;
         end
      end

      assign out_x             = acc_q;
      assign out_idx           = idx_hold_q;
      assign out_any_since_clr = acc_q;
   end else begin : g_pass
      assign out_x             = vld_q[L-1] & x_all[TOT-1];
      assign out_idx           = vld_q[L-1] ? idx_all[(TOT-1)*IDXW +: IDXW] : '0;
      assign out_any_since_clr = 1'b0;
   end

   // Signals only consumed by one of the two output modes.
   logic unused_sink;
   assign unused_sink = ^{tap_x, tap_idx, clr, x_all, idx_all, vld_chain};

endmodule

// File: tb/tb_seh_or_tree_pipe.sv
// tb_seh_or_tree_pipe
//   Three instances: A (WIDTH=16, FANIN=4, pass-through), S (same, sticky),
//   W (WIDTH=5, FANIN=4, partial last group). All have L=2.
module tb_seh_or_tree_pipe;
   import seh_or_pkg::*;

   localparam int LAT = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   int   cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        a_valid, a_clr, a_out_valid, a_out_x, a_out_any;
   logic [15:0] a_data, a_mask;
   logic [3:0]  a_out_idx;

   logic        s_valid, s_clr, s_out_valid, s_out_x, s_out_any;
   logic [15:0] s_data, s_mask;
   logic [3:0]  s_out_idx;

   logic        w_valid, w_clr, w_out_valid, w_out_x, w_out_any;
   logic [4:0]  w_data, w_mask;
   logic [2:0]  w_out_idx;

   seh_or_tree_pipe #(.WIDTH(16), .FANIN(4), .STICKY(0)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_mask(a_mask),
      .clr(a_clr), .out_valid(a_out_valid), .out_x(a_out_x), .out_idx(a_out_idx),
      .out_any_since_clr(a_out_any)
   );

   seh_or_tree_pipe #(.WIDTH(16), .FANIN(4), .STICKY(1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_mask(s_mask),
      .clr(s_clr), .out_valid(s_out_valid), .out_x(s_out_x), .out_idx(s_out_idx),
      .out_any_since_clr(s_out_any)
   );

   seh_or_tree_pipe #(.WIDTH(5), .FANIN(4), .STICKY(0)) u_dut_w (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_data(w_data), .in_mask(w_mask),
      .clr(w_clr), .out_valid(w_out_valid), .out_x(w_out_x), .out_idx(w_out_idx),
      .out_any_since_clr(w_out_any)
   );

   // ---------------- scoreboard ----------------
   or_bundle_t exp_a_q[$], exp_s_q[$], exp_w_q[$];
   int         cyc_a_q[$], cyc_s_q[$], cyc_w_q[$];
   int         n_vec;
   int         n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic or_bundle_t mk(input logic x, input logic [7:0] idx);
      or_bundle_t b;
      b.valid = 1'b1;
      b.x     = x;
      b.idx   = idx;
      return b;
   endfunction

   // ---------------- monitors ----------------
   logic       a_ev, s_ev, w_ev;
   or_bundle_t a_e, s_e, w_e;

   always @(negedge clk) begin
      if (!rst) begin
         while (cyc_a_q.size() > 0 && cyc_a_q[0] < cyc) begin
            void'(cyc_a_q.pop_front());
            void'(exp_a_q.pop_front());
         end
         a_ev = (cyc_a_q.size() > 0) && (cyc_a_q[0] == cyc);
         chk("a_valid", 32'(a_out_valid), 32'(a_ev));
         if (a_ev) begin
            a_e = exp_a_q.pop_front();
            void'(cyc_a_q.pop_front());
            chk("a_x", 32'(a_out_x), 32'(a_e.x));
            chk("a_idx", 32'(a_out_idx), 32'(a_e.idx));
         end else begin
            chk("a_idle_x", 32'(a_out_x), 32'd0);
            chk("a_idle_idx", 32'(a_out_idx), 32'd0);
         end
         chk("a_any", 32'(a_out_any), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         while (cyc_s_q.size() > 0 && cyc_s_q[0] < cyc) begin
            void'(cyc_s_q.pop_front());
            void'(exp_s_q.pop_front());
         end
         s_ev = (cyc_s_q.size() > 0) && (cyc_s_q[0] == cyc);
         chk("s_valid", 32'(s_out_valid), 32'(s_ev));
         if (s_ev) begin
            s_e = exp_s_q.pop_front();
            void'(cyc_s_q.pop_front());
            chk("s_x", 32'(s_out_x), 32'(s_e.x));
            chk("s_idx", 32'(s_out_idx), 32'(s_e.idx));
            chk("s_any", 32'(s_out_any), 32'(s_e.x));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         while (cyc_w_q.size() > 0 && cyc_w_q[0] < cyc) begin
            void'(cyc_w_q.pop_front());
            void'(exp_w_q.pop_front());
         end
         w_ev = (cyc_w_q.size() > 0) && (cyc_w_q[0] == cyc);
         chk("w_valid", 32'(w_out_valid), 32'(w_ev));
         if (w_ev) begin
            w_e = exp_w_q.pop_front();
            void'(cyc_w_q.pop_front());
            chk("w_x", 32'(w_out_x), 32'(w_e.x));
            chk("w_idx", 32'(w_out_idx), 32'(w_e.idx));
         end else begin
            chk("w_idle_x", 32'(w_out_x), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         a_valid = 1'b0;
         s_valid = 1'b0;
         w_valid = 1'b0;
         s_clr   = 1'b0;
      end
   endtask

   task automatic drive_a(input logic [15:0] d, input logic [15:0] m,
                          input logic x, input logic [7:0] idx);
      step();
      a_valid = 1'b1;
      a_data  = d;
      a_mask  = m;
      exp_a_q.push_back(mk(x, idx));
      cyc_a_q.push_back(cyc + LAT);
   endtask

   task automatic drive_s(input logic [15:0] d, input logic x, input logic [7:0] idx);
      step();
      s_valid = 1'b1;
      s_data  = d;
      s_mask  = 16'hFFFF;
      exp_s_q.push_back(mk(x, idx));
      cyc_s_q.push_back(cyc + LAT);
   endtask

   task automatic drive_w(input logic [4:0] d, input logic x, input logic [7:0] idx);
      step();
      w_valid = 1'b1;
      w_data  = d;
      w_mask  = 5'h1F;
      exp_w_q.push_back(mk(x, idx));
      cyc_w_q.push_back(cyc + LAT);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc = 0; n_vec = 0; n_err = 0;
      rst = 1'b1;
      a_valid = 1'b0; a_clr = 1'b0; a_data = '0; a_mask = '0;
      s_valid = 1'b0; s_clr = 1'b0; s_data = '0; s_mask = '0;
      w_valid = 1'b0; w_clr = 1'b0; w_data = '0; w_mask = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_x", 32'(a_out_x), 32'd0);
      chk("rst_a_idx", 32'(a_out_idx), 32'd0);
      chk("rst_s_x", 32'(s_out_x), 32'd0);
      chk("rst_s_any", 32'(s_out_any), 32'd0);
      chk("rst_w_valid", 32'(w_out_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single sample, then the idle monitor checks the output returns to 0.
      drive_a(16'h0100, 16'hFFFF, 1'b1, 8'd8);
      idle(3);
      // Mask gating.
      drive_a(16'h8001, 16'h8000, 1'b1, 8'd15);
      drive_a(16'h8001, 16'h0000, 1'b0, 8'd0);
      idle(3);
      // Back-to-back stream, no bubbles.
      drive_a(16'h0000, 16'hFFFF, 1'b0, 8'd0);
      drive_a(16'h0004, 16'hFFFF, 1'b1, 8'd2);
      drive_a(16'h0000, 16'hFFFF, 1'b0, 8'd0);
      drive_a(16'hFFFF, 16'hFFFF, 1'b1, 8'd0);
      drive_a(16'h0A50, 16'hFFF0, 1'b1, 8'd4);
      drive_a(16'h8000, 16'hFFFF, 1'b1, 8'd15);
      drive_a(16'h0F0F, 16'hF0F0, 1'b0, 8'd0);
      idle(3);

      // Partial last group.
      drive_w(5'h10, 1'b1, 8'd4);
      drive_w(5'h00, 1'b0, 8'd0);
      drive_w(5'h0C, 1'b1, 8'd2);
      idle(3);

      // Sticky: first index is held even when a lower one follows.
      drive_s(16'h0010, 1'b1, 8'd4);
      drive_s(16'h0002, 1'b1, 8'd4);
      idle(3);
      @(negedge clk);
      chk("s_hold_x", 32'(s_out_x), 32'd1);
      chk("s_hold_idx", 32'(s_out_idx), 32'd4);
      // Clear alone.
      step();
      s_clr = 1'b1;
      step();
      s_clr = 1'b0;
      @(negedge clk);
      chk("s_clr_x", 32'(s_out_x), 32'd0);
      chk("s_clr_idx", 32'(s_out_idx), 32'd0);
      chk("s_clr_any", 32'(s_out_any), 32'd0);
      // Re-arm, then clear coinciding with a new result: the new index wins.
      drive_s(16'h0010, 1'b1, 8'd4);
      idle(3);
      drive_s(16'h0200, 1'b1, 8'd9);
      step();
      s_valid = 1'b0;
      s_clr   = 1'b1;
      step();
      s_clr   = 1'b0;
      idle(2);

      // Reset mid-stream with two samples in flight.
      drive_a(16'h0020, 16'hFFFF, 1'b1, 8'd5);
      drive_a(16'h0040, 16'hFFFF, 1'b1, 8'd6);
      step();
      a_valid = 1'b0;
      chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
      chk("pre_rst_idx", 32'(a_out_idx), 32'd5);
      #2 rst = 1'b1;
      exp_a_q.delete(); cyc_a_q.delete();
      exp_s_q.delete(); cyc_s_q.delete();
      exp_w_q.delete(); cyc_w_q.delete();
      #1;
      chk("async_rst_valid", 32'(a_out_valid), 32'd0);
      chk("async_rst_x", 32'(a_out_x), 32'd0);
      chk("async_rst_idx", 32'(a_out_idx), 32'd0);
      chk("async_rst_s_x", 32'(s_out_x), 32'd0);
      chk("async_rst_s_idx", 32'(s_out_idx), 32'd0);
      step();
      step();
      rst = 1'b0;
      idle(4);
      // First sample after reset appears exactly LAT cycles later.
      drive_a(16'h0001, 16'hFFFF, 1'b1, 8'd0);
      idle(4);

      chk("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
      chk("s_queue_drained", 32'(exp_s_q.size()), 32'd0);
      chk("w_queue_drained", 32'(exp_w_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
